// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: element/beat geometry and SRAM address width,
// common to the weight DMA, its readers and the register slices.
package cnn_pkg;

  localparam int unsigned CNN_DW = 8;
  localparam int unsigned CNN_DN = 6;
  localparam int unsigned CNN_AW = 14;

  // Beat on the data stream: DN*DW payload bits plus first/last flags.
  function automatic int unsigned beat_w(input int unsigned dn, input int unsigned dw);
    return dn * dw + 2;
  endfunction

  localparam int unsigned CNN_BEAT_W = beat_w(CNN_DN, CNN_DW);

  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_OPEN = 1'b1
  } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head word is visible on
// dout whenever empty is low. DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage is cleared too, so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/cwbuf_reader.sv
// Conv-weight buffer reader: turns {addr,first,last} beats into SRAM reads and
// returns data beats in order under credit flow control. Optional frame
// checking is enabled by defining CWBUF_RD_FRAME_CHK_EN.
module cwbuf_reader
  import cnn_pkg::*;
#(
  parameter int unsigned DW = CNN_DW,
  parameter int unsigned DN = CNN_DN,
  parameter int unsigned AW = CNN_AW,
  parameter int unsigned FD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr_m_addr,
  input  logic                 addr_m_first,
  input  logic                 addr_m_last,
  input  logic                 addr_m_valid,
  output logic                 addr_m_ready,
  output logic                 mem_ren,
  output logic [AW-1:0]        mem_raddr,
  input  logic [DN*DW-1:0]     mem_rdata,
  output logic [DN*DW-1:0]     rd_s_data,
  output logic                 rd_s_first,
  output logic                 rd_s_last,
  output logic                 rd_s_valid,
  input  logic                 rd_s_ready,
  output logic                 err
);

  localparam int unsigned BW = beat_w(DN, DW);
  localparam int unsigned CW = $clog2(FD) + 1;

  logic [CW-1:0] cnt;
  logic [CW:0]   credit_use;
  logic          inflight;
  logic          first_q;
  logic          last_q;
  logic [AW-1:0] raddr_q;
  logic          accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [BW-1:0] head;

  assign pop        = rd_s_valid & rd_s_ready;
  // Beats already owed downstream after this cycle's pop; one extra bit keeps
  // the sum from wrapping when cnt == FD.
  assign credit_use = (CW+1)'(cnt) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign addr_m_ready = (credit_use < (CW+1)'(FD));
  assign accept     = addr_m_valid & addr_m_ready;

  always_comb begin
    mem_ren   = accept;
    mem_raddr = raddr_q;
    if (accept) begin
      mem_raddr = addr_m_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      raddr_q  <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        first_q <= addr_m_first;
        last_q  <= addr_m_last;
        raddr_q <= addr_m_addr;
      end
    end
  end

  sync_fifo #(
    .WIDTH (BW),
    .DEPTH (FD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({mem_rdata, first_q, last_q}),
    .pop   (pop),
    .dout  (head),
    .cnt   (cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_s_valid = ~fifo_empty;
  assign rd_s_data  = head[BW-1:2];
  assign rd_s_first = head[1];
  assign rd_s_last  = head[0];

  // The read return is pushed unconditionally; credit must have reserved room.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(inflight && fifo_full && !pop));

`ifdef CWBUF_RD_FRAME_CHK_EN
  frame_state_e frame_q;
  logic         err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= FR_IDLE;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (addr_m_first ? (frame_q == FR_OPEN) : (frame_q == FR_IDLE)) begin
        err_q <= 1'b1;
      end
      if (addr_m_last) begin
        frame_q <= FR_IDLE;
      end else if (addr_m_first) begin
        frame_q <= FR_OPEN;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
